// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU op sequencer: op codes, FSM states, default width,
// and the op/operand legality check.
package alu_seq_pkg;

  localparam int DEFAULT_N = 4;

  typedef enum logic [3:0] {
    OP_AND = 4'h0,
    OP_OR  = 4'h1,
    OP_ADD = 4'h2,
    OP_INC = 4'h3,
    OP_DEC = 4'h4,
    OP_NOT = 4'h5,
    OP_SUB = 4'h6,
    OP_XOR = 4'h7,
    OP_SHL = 4'h8,
    OP_SHR = 4'h9
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_e;

  // Shifts are only legal for a shift amount in 1..n; b arrives zero-extended.
  function automatic logic op_is_valid(input logic [3:0] op, input logic [31:0] b,
                                       input int unsigned n);
    if (op > OP_SHR) return 1'b0;
    if (op == OP_SHL || op == OP_SHR) return (b != 32'd0) && (b <= n);
    return 1'b1;
  endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Two-entry in-order request FIFO with a registered occupancy count.
module alu_req_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr, rd_ptr;
  logic         push_ok, pop_ok;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign push_ok  = push && (count != 2'd2);
  assign pop_ok   = pop && (count != 2'd0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Queues ALU requests, drives an external combinational ALU one op at a time,
// and returns captured results in order over a valid/ready response port.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [N-1:0] req_a,
  input  logic [N-1:0] req_b,
  input  logic         req_flag,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic         alu_flag_in,
  output logic [3:0]   alu_control,
  input  logic [N-1:0] alu_result,
  input  logic         alu_flags,
  input  logic         alu_cero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_result,
  output logic         rsp_flag,
  output logic         rsp_cero,
  output logic         rsp_err,
  output logic [7:0]   op_count
);

  localparam int EW = 4 + 2*N + 1;

  seq_state_e   state, state_d;
  logic [EW-1:0] push_data, head;
  logic [1:0]   count;
  logic         push, pop, head_ok;
  logic [3:0]   head_op, cur_op;
  logic [N-1:0] head_a, head_b, cur_a, cur_b;
  logic         head_flag, cur_flag;

  assign req_ready = (count < 2'd2);
  assign push      = req_valid && req_ready;
  assign push_data = {req_op, req_a, req_b, req_flag};

  assign head_flag = head[0];
  assign head_b    = head[N:1];
  assign head_a    = head[2*N:N+1];
  assign head_op   = head[EW-1:2*N+1];
  assign head_ok   = op_is_valid(head_op, 32'(head_b), N);

  alu_req_fifo #(.W(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .count     (count)
  );

  assign rsp_valid = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (count != 2'd0) begin
          pop     = 1'b1;
          state_d = head_ok ? ST_DRIVE : ST_RESP;
        end
      end
      ST_DRIVE: state_d = ST_LATCH;
      ST_LATCH: state_d = ST_RESP;
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_op      <= 4'h0;
      cur_a       <= '0;
      cur_b       <= '0;
      cur_flag    <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_flag_in <= 1'b0;
      alu_control <= 4'h0;
      rsp_result  <= '0;
      rsp_flag    <= 1'b0;
      rsp_cero    <= 1'b0;
      rsp_err     <= 1'b0;
      op_count    <= 8'd0;
    end else begin
      if (state == ST_IDLE && pop) begin
        cur_op   <= head_op;
        cur_a    <= head_a;
        cur_b    <= head_b;
        cur_flag <= head_flag;
        // Rejected ops skip the ALU entirely; its inputs keep their last values.
        if (!head_ok) begin
          rsp_result <= '0;
          rsp_flag   <= 1'b0;
          rsp_cero   <= 1'b1;
          rsp_err    <= 1'b1;
        end
      end
      if (state == ST_DRIVE) begin
        alu_a       <= cur_a;
        alu_b       <= cur_b;
        alu_flag_in <= cur_flag;
        alu_control <= cur_op;
      end
      if (state == ST_LATCH) begin
        rsp_result <= alu_result;
        rsp_flag   <= alu_flags;
        rsp_cero   <= alu_cero;
        rsp_err    <= 1'b0;
      end
      if (rsp_valid && rsp_ready && !rsp_err) op_count <= op_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural CPU ALU on the alu_* port.
module tb_alu_op_sequencer;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_flag;
  logic [3:0]   req_op;
  logic [N-1:0] req_a, req_b;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic         alu_flag_in, alu_flags, alu_cero;
  logic [3:0]   alu_control;
  logic         rsp_valid, rsp_ready, rsp_flag, rsp_cero, rsp_err;
  logic [N-1:0] rsp_result;
  logic [7:0]   op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_flag(req_flag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_flag_in(alu_flag_in), .alu_control(alu_control),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_cero(alu_cero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flag(rsp_flag), .rsp_cero(rsp_cero), .rsp_err(rsp_err), .op_count(op_count)
  );

  // CPU ALU: flags is carry/borrow out, cero is result == 0.
  logic [N:0] alu_w;
  always_comb begin
    alu_w = '0;
    case (alu_control)
      4'h0: alu_w = {1'b0, alu_a & alu_b};
      4'h1: alu_w = {1'b0, alu_a | alu_b};
      4'h2: alu_w = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_flag_in};
      4'h3: alu_w = {1'b0, alu_a} + 1'b1;
      4'h4: alu_w = {1'b0, alu_a} - 1'b1;
      4'h5: alu_w = {1'b0, ~alu_a};
      4'h6: alu_w = {1'b0, alu_a} - {1'b0, alu_b};
      4'h7: alu_w = {1'b0, alu_a ^ alu_b};
      4'h8: alu_w = {1'b0, alu_a << alu_b};
      4'h9: alu_w = {1'b0, alu_a >> alu_b};
      default: alu_w = '0;
    endcase
  end
  assign alu_result = alu_w[N-1:0];
  assign alu_flags  = alu_w[N];
  assign alu_cero   = (alu_w[N-1:0] == '0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic f);
    req_op = op; req_a = a; req_b = b; req_flag = f; req_valid = 1'b1;
    check("send_ready", req_ready, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check(tag, rsp_valid, 1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [N-1:0] exp_q [4];
  int  got;
  logic acc, hs, saw_valid;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = 4'h0; req_a = '0; req_b = '0;
    req_flag = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_op_count", op_count, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_rsp_cero", rsp_cero, 0);
    check("rst_alu_control", alu_control, 0);

    // AND C&A: exact t+4 latency
    send(4'h0, 4'hC, 4'hA, 1'b0);
    tick();
    check("and_lat_t2", rsp_valid, 0);
    tick();
    check("and_lat_t3", rsp_valid, 0);
    tick();
    check("and_lat_t4", rsp_valid, 1);
    check("and_result", rsp_result, 4'h8);
    check("and_cero", rsp_cero, 0);
    check("and_err", rsp_err, 0);
    handshake();
    check("and_valid_drop", rsp_valid, 0);
    check("and_op_count", op_count, 1);

    // SUB 5-5 -> zero
    send(4'h6, 4'h5, 4'h5, 1'b0);
    wait_rsp("sub_valid");
    check("sub_result", rsp_result, 4'h0);
    check("sub_cero", rsp_cero, 1);
    check("sub_err", rsp_err, 0);
    check("sub_flag", rsp_flag, 0);
    handshake();
    check("sub_op_count", op_count, 2);

    // Illegal op code: response at t+2
    send(4'hB, 4'h1, 4'h1, 1'b0);
    tick();
    check("badop_lat_t2", rsp_valid, 1);
    check("badop_err", rsp_err, 1);
    check("badop_result", rsp_result, 0);
    check("badop_cero", rsp_cero, 1);
    check("badop_alu_ctl", alu_control, 4'h6);
    handshake();
    check("badop_op_count", op_count, 2);

    // SHL with shift amount beyond width
    send(4'h8, 4'h3, 4'h5, 1'b0);
    wait_rsp("shl5_valid");
    check("shl5_err", rsp_err, 1);
    check("shl5_result", rsp_result, 0);
    check("shl5_cero", rsp_cero, 1);
    check("shl5_alu_ctl", alu_control, 4'h6);
    handshake();
    check("shl5_op_count", op_count, 2);

    // SHR with zero shift amount is illegal
    send(4'h9, 4'h8, 4'h0, 1'b0);
    wait_rsp("shr0_valid");
    check("shr0_err", rsp_err, 1);
    handshake();

    // SHR by N is the largest legal shift
    send(4'h9, 4'h8, 4'h4, 1'b0);
    wait_rsp("shr4_valid");
    check("shr4_err", rsp_err, 0);
    check("shr4_result", rsp_result, 4'h0);
    handshake();
    check("shr4_op_count", op_count, 3);

    // Four back-to-back requests with the response side stalled
    send(4'h2, 4'h1, 4'h2, 1'b0);
    send(4'h7, 4'hF, 4'hF, 1'b0);
    send(4'h3, 4'h7, 4'h0, 1'b0);
    check("full_req_ready", req_ready, 0);
    req_op = 4'h1; req_a = 4'h0; req_b = 4'h0; req_flag = 1'b0; req_valid = 1'b1;
    tick(); tick();
    check("full_req_ready_hold", req_ready, 0);
    exp_q[0] = 4'h3; exp_q[1] = 4'h0; exp_q[2] = 4'h8; exp_q[3] = 4'h0;
    rsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      acc = req_valid && req_ready;
      hs  = rsp_valid && rsp_ready;
      if (hs) begin
        check($sformatf("b2b_result%0d", got), rsp_result, exp_q[got]);
        got++;
      end
      tick();
      if (acc) req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    check("b2b_count", got, 4);
    check("b2b_req_dropped", req_valid, 0);
    check("b2b_op_count", op_count, 7);

    // Stalled response must hold steady
    send(4'h7, 4'h5, 4'h3, 1'b0);
    wait_rsp("stall_valid");
    for (int i = 0; i < 5; i++) begin
      check("stall_result", rsp_result, 4'h6);
      check("stall_valid_hold", rsp_valid, 1);
      check("stall_op_count", op_count, 7);
      tick();
    end
    handshake();
    check("stall_op_count_inc", op_count, 8);
    tick();
    check("stall_op_count_once", op_count, 8);

    // Reset while in DRIVE with one request queued
    send(4'h2, 4'h1, 4'h1, 1'b0);
    send(4'h2, 4'h2, 4'h2, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_op_count", op_count, 0);
    rsp_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) saw_valid = 1'b1;
      tick();
    end
    check("midrst_no_rsp", saw_valid, 0);
    check("midrst_alu_ctl", alu_control, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
